uart_irq_ctrl: RTL
==================

Name: uart_irq_ctrl

Overview:
Parametrised 16550-style interrupt controller for the UART; next generation of the basic IRQ block.
- Tracks five interrupt sources: line status (RLS), RX data available (RDA), character timeout (CTI), TX holding empty (THRE) and optional modem status (MS).
- Holds per-source pending state, prioritises the sources and produces an IIR code plus one IRQ line for the register file.
- Adds depth-scaled `>=` trigger levels, an internal character-timeout counter, edge-set THRE with read-clear, and defined set/clear collision rules.

Parameters:
- FIFO_DEPTH, 16: RX/TX FIFO depth. Power of two, minimum 4.
- LOG_FIFO_DEPTH, $clog2(FIFO_DEPTH): width basis for element counts.
- TO_BITS, 40: bit periods of RX idle (4 chars x 10 bits) before CTI fires.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, synchronous, active-low
- ier_i  in  4  enables: [0] RDA/CTI, [1] THRE, [2] RLS, [3] MS
- fifo_en_i  in  1  FIFO mode; 0 = 16450 mode
- trg_level_i  in  2  RX trigger select
- rx_elem_i  in  LOG_FIFO_DEPTH+1  RX FIFO occupancy
- tx_elem_i  in  LOG_FIFO_DEPTH+1  TX FIFO occupancy
- rx_push_i  in  1  RX FIFO write strobe
- rx_pop_i  in  1  RX FIFO read strobe
- tx_push_i  in  1  TX FIFO write strobe
- bit_tick_i  in  1  one-cycle pulse per bit period
- line_err_i  in  1  pulse: parity, framing, overrun or break detected
- lsr_rd_i  in  1  LSR read strobe
- iir_rd_i  in  1  IIR read strobe
- msr_rd_i  in  1  MSR read strobe
- msr_delta_i  in  4  modem delta flags (DCTS, DDSR, TERI, DDCD)
- iir_o  out  4  [0] = no interrupt pending (active high); [3:1] = source ID
- irq_o  out  1  interrupt request

Behaviour:
- Reset (rst_n_i low at a clock edge): all pending bits 0, timeout counter 0, THRE edge register 0. Outputs: iir_o = 4'b0001, irq_o = 0.
- Reset mid-operation discards all pending state, regardless of strobes in the same cycle.
- Pending bits are registered. iir_o and irq_o decode combinationally from pending AND ier_i.
  - Event at edge N is visible on iir_o/irq_o after edge N+1 (1-cycle latency).
  - Disabled sources may still latch pending but are masked from iir_o/irq_o.
- Trigger threshold T:
  - fifo_en_i = 0: T = 1.
  - Otherwise trg_level_i selects: 00 -> 1, 01 -> FIFO_DEPTH/4, 10 -> FIFO_DEPTH/2, 11 -> FIFO_DEPTH-2.
  - Compare rx_elem_i >= T (unsigned, width LOG_FIFO_DEPTH+1).
- RLS: set on line_err_i; cleared on lsr_rd_i. Set wins over clear in the same cycle.
- RDA: level source, registered each cycle as (rx_elem_i >= T). Not sticky.
- CTI (only when fifo_en_i = 1):
  - Counter clears when rx_elem_i == 0, on rx_push_i, or on rx_pop_i.
  - Otherwise increments on bit_tick_i and saturates at TO_BITS.
  - CTI pending = (count == TO_BITS) and rx_elem_i != 0.
  - Clears on the next push/pop or when the FIFO empties.
  - fifo_en_i = 0 forces counter and CTI to 0.
- THRE:
  - Set on the rising edge of (ier_i[1] & tx_elem_i == 0); enabling THRE while the TX FIFO is empty therefore raises it.
  - Cleared on tx_push_i, or on iir_rd_i while iir_o reports THRE.
  - A new rising edge in the same cycle as a clear wins (stays set).
- Priority, highest first, with iir_o[3:1] code:
  - RLS = 011
  - RDA = 010
  - CTI = 110
  - THRE = 001
  - MS = 000, with iir_o[0] = 0
- iir_o[0] = 1 only when no enabled source is pending. irq_o = ~iir_o[0].
- rx_push_i and rx_pop_i together: counter clears; occupancy handling belongs to the FIFO.

Optional Feature:
- Macro: UART_IRQ_MSI_EN.
- Defined: MS pending sets on any msr_delta_i bit and clears on msr_rd_i (set wins over clear). It is reported at lowest priority when ier_i[3] = 1.
- Undefined: MS logic is absent, ier_i[3], msr_delta_i and msr_rd_i are ignored, and ID 000 with iir_o[0] = 0 is never produced.

Decomposition:
- Shared package uart_pkg holds:
  - IIR ID localparams (IIR_RLS, IIR_RDA, IIR_CTI, IIR_THRE, IIR_MS, IIR_NONE).
  - IER bit index constants.
  - The trg_level enum.
- One sub-module, uart_irq_tmo: timeout counter with params TO_BITS and LOG_FIFO_DEPTH, producing a cti_o level.
- Priority encode stays in the top module.

Test Plan:
- Reset with strobes active: rst_n_i = 0 for 2 cycles while line_err_i = 1 -> iir_o = 4'b0001, irq_o = 0.
- Trigger levels: fifo_en_i = 1, trg_level_i = 10, FIFO_DEPTH = 16, ier_i = 0001, rx_elem_i 7 -> 8 -> 9:
  - 7: iir_o stays 0001.
  - 8 and 9: iir_o = 0100, irq_o = 1.
  - Dropping to 7 returns iir_o to 0001.
- Timeout: rx_elem_i = 1, 40 bit_tick_i pulses, no push/pop -> iir_o = 1100 after the 40th tick. rx_pop_i -> 0001 the next cycle.
- Priority and read-clear: line_err_i pulse with RDA active, ier_i = 0101 -> iir_o = 0110. lsr_rd_i -> iir_o = 0100.
- THRE edge and clear: tx_elem_i -> 0 with ier_i = 0010 -> iir_o = 0010.
  - iir_rd_i -> 0001.
  - tx_push_i then tx_elem_i -> 0 again -> 0010.
  - iir_rd_i in the same cycle as a new edge -> stays 0010.
- UART_IRQ_MSI_EN: msr_delta_i = 0001, ier_i = 1000 -> iir_o = 0000 (defined) or 0001 (undefined). msr_rd_i -> 0001.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the interrupt controller:
//   - IIR source ID codes (the value placed on iir_o[3:1])
//   - bit positions of the interrupt enable register
//   - RX trigger level selector encoding
// -----------------------------------------------------------------------------
package uart_pkg;

   // IIR[3:1] source identifiers
   localparam logic [2:0] IIR_RLS  = 3'b011;
   localparam logic [2:0] IIR_RDA  = 3'b010;
   localparam logic [2:0] IIR_CTI  = 3'b110;
   localparam logic [2:0] IIR_THRE = 3'b001;
   localparam logic [2:0] IIR_MS   = 3'b000;
   // Full IIR value when nothing enabled is pending (bit 0 set)
   localparam logic [3:0] IIR_NONE = 4'b0001;

   // IER bit positions
   localparam int unsigned IER_RDA  = 0;
   localparam int unsigned IER_THRE = 1;
   localparam int unsigned IER_RLS  = 2;
   localparam int unsigned IER_MS   = 3;

   // RX trigger level select
   typedef enum logic [1:0] {
      TRG_ONE     = 2'b00,
      TRG_QUARTER = 2'b01,
      TRG_HALF    = 2'b10,
      TRG_NEAR    = 2'b11
   } trg_level_e;

endpackage : uart_pkg

// File: rtl/uart_irq_tmo.sv
// -----------------------------------------------------------------------------
// uart_irq_tmo
// Character-timeout tracker. Counts bit periods while the RX FIFO holds data
// and sees no push/pop traffic; flags a timeout once TO_BITS periods elapse.
//
// Ports:
//   clk_i      clock
//   rst_n_i    synchronous active-low reset
//   fifo_en_i  FIFO mode; timeout is inactive when 0
//   rx_elem_i  RX FIFO occupancy
//   rx_push_i  RX FIFO write strobe (restarts the count)
//   rx_pop_i   RX FIFO read strobe (restarts the count)
//   bit_tick_i one-cycle pulse per bit period
//   cti_o      registered timeout-pending level
// -----------------------------------------------------------------------------
module uart_irq_tmo
   import uart_pkg::*;
#(
   parameter int unsigned TO_BITS        = 40,
   parameter int unsigned LOG_FIFO_DEPTH = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      fifo_en_i,
   input  logic [LOG_FIFO_DEPTH:0]   rx_elem_i,
   input  logic                      rx_push_i,
   input  logic                      rx_pop_i,
   input  logic                      bit_tick_i,
   output logic                      cti_o
);

   localparam int unsigned CNT_W = $clog2(TO_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TO_BITS);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             rx_empty_s;
   logic             cti_r;

   assign rx_empty_s = (rx_elem_i == {(LOG_FIFO_DEPTH+1){1'b0}});

   // Next counter value: restart on empty FIFO or any FIFO traffic, saturate at CNT_MAX
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (!fifo_en_i) begin
         cnt_nxt_s = {CNT_W{1'b0}};
      end else if (rx_empty_s || rx_push_i || rx_pop_i) begin
         cnt_nxt_s = {CNT_W{1'b0}};
      end else if (bit_tick_i && (cnt_r != CNT_MAX)) begin
         cnt_nxt_s = cnt_r + CNT_W'(1);
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Counter and timeout-pending registers; pending derives from the next count so
   // it appears in the same cycle the counter reaches the limit
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_r <= {CNT_W{1'b0}};
         cti_r <= 1'b0;
      end else begin
         cnt_r <= cnt_nxt_s;
         cti_r <= fifo_en_i && !rx_empty_s && (cnt_nxt_s == CNT_MAX);
      end
   end

   assign cti_o = cti_r;

endmodule : uart_irq_tmo

// File: rtl/uart_irq_ctrl.sv
// -----------------------------------------------------------------------------
// uart_irq_ctrl
// 16550-style interrupt controller. Keeps per-source pending state for line
// status, RX data available, character timeout, TX holding empty and (optionally)
// modem status, then prioritises the enabled sources into an IIR code and IRQ.
//
// Build option: define UART_IRQ_MSI_EN to include the modem-status source.
//
// Ports:
//   clk_i        clock
//   rst_n_i      synchronous active-low reset
//   ier_i        enables [0] RDA/CTI [1] THRE [2] RLS [3] MS
//   fifo_en_i    FIFO mode (0 = 16450 mode, trigger fixed at 1, no timeout)
//   trg_level_i  RX trigger select
//   rx_elem_i    RX FIFO occupancy
//   tx_elem_i    TX FIFO occupancy
//   rx_push_i    RX FIFO write strobe
//   rx_pop_i     RX FIFO read strobe
//   tx_push_i    TX FIFO write strobe
//   bit_tick_i   one pulse per bit period
//   line_err_i   line error pulse
//   lsr_rd_i     LSR read strobe
//   iir_rd_i     IIR read strobe
//   msr_rd_i     MSR read strobe
//   msr_delta_i  modem delta flags
//   iir_o        [0] no interrupt pending, [3:1] source ID
//   irq_o        interrupt request
// -----------------------------------------------------------------------------
module uart_irq_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter int unsigned LOG_FIFO_DEPTH = $clog2(FIFO_DEPTH),
   parameter int unsigned TO_BITS        = 40
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic [3:0]                ier_i,
   input  logic                      fifo_en_i,
   input  logic [1:0]                trg_level_i,
   input  logic [LOG_FIFO_DEPTH:0]   rx_elem_i,
   input  logic [LOG_FIFO_DEPTH:0]   tx_elem_i,
   input  logic                      rx_push_i,
   input  logic                      rx_pop_i,
   input  logic                      tx_push_i,
   input  logic                      bit_tick_i,
   input  logic                      line_err_i,
   input  logic                      lsr_rd_i,
   input  logic                      iir_rd_i,
   input  logic                      msr_rd_i,
   input  logic [3:0]                msr_delta_i,
   output logic [3:0]                iir_o,
   output logic                      irq_o
);

   localparam int unsigned ELEM_W = LOG_FIFO_DEPTH + 1;
   localparam logic [ELEM_W-1:0] TRG_T_ONE     = ELEM_W'(1);
   localparam logic [ELEM_W-1:0] TRG_T_QUARTER = ELEM_W'(FIFO_DEPTH / 4);
   localparam logic [ELEM_W-1:0] TRG_T_HALF    = ELEM_W'(FIFO_DEPTH / 2);
   localparam logic [ELEM_W-1:0] TRG_T_NEAR    = ELEM_W'(FIFO_DEPTH - 2);

   logic [ELEM_W-1:0] trg_thr_s;
   logic              rls_r;
   logic              rda_r;
   logic              cti_s;
   logic              thre_r;
   logic              thre_cond_s;
   logic              thre_cond_r;
   logic              thre_rise_s;
   logic              thre_rd_clr_s;
   logic              ms_s;
   logic [3:0]        iir_s;

   // RX trigger threshold; 16450 mode always interrupts on a single character
   always_comb begin
      trg_thr_s = TRG_T_ONE;
      if (!fifo_en_i) begin
         trg_thr_s = TRG_T_ONE;
      end else begin
         case (trg_level_e'(trg_level_i))
            TRG_ONE:     trg_thr_s = TRG_T_ONE;
            TRG_QUARTER: trg_thr_s = TRG_T_QUARTER;
            TRG_HALF:    trg_thr_s = TRG_T_HALF;
            TRG_NEAR:    trg_thr_s = TRG_T_NEAR;
            default:     trg_thr_s = TRG_T_ONE;
         endcase
      end
   end

   // THRE is edge-triggered on "enabled and TX empty" so enabling it while empty raises it
   assign thre_cond_s   = ier_i[IER_THRE] && (tx_elem_i == {ELEM_W{1'b0}});
   assign thre_rise_s   = thre_cond_s && !thre_cond_r;
   assign thre_rd_clr_s = iir_rd_i && !iir_s[0] && (iir_s[3:1] == IIR_THRE);

   // Pending registers for RLS, RDA and THRE; set beats clear where both occur
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         rls_r       <= 1'b0;
         rda_r       <= 1'b0;
         thre_r      <= 1'b0;
         thre_cond_r <= 1'b0;
      end else begin
         if (line_err_i) begin
            rls_r <= 1'b1;
         end else if (lsr_rd_i) begin
            rls_r <= 1'b0;
         end else begin
            rls_r <= rls_r;
         end

         rda_r       <= (rx_elem_i >= trg_thr_s);
         thre_cond_r <= thre_cond_s;

         if (thre_rise_s) begin
            thre_r <= 1'b1;
         end else if (tx_push_i || thre_rd_clr_s) begin
            thre_r <= 1'b0;
         end else begin
            thre_r <= thre_r;
         end
      end
   end

   uart_irq_tmo #(
      .TO_BITS        (TO_BITS),
      .LOG_FIFO_DEPTH (LOG_FIFO_DEPTH)
   ) u_tmo (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .fifo_en_i  (fifo_en_i),
      .rx_elem_i  (rx_elem_i),
      .rx_push_i  (rx_push_i),
      .rx_pop_i   (rx_pop_i),
      .bit_tick_i (bit_tick_i),
      .cti_o      (cti_s)
   );

`ifdef UART_IRQ_MSI_EN
   logic ms_r;

   // Modem-status pending: any delta flag sets, MSR read clears, set wins
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         ms_r <= 1'b0;
      end else if (|msr_delta_i) begin
         ms_r <= 1'b1;
      end else if (msr_rd_i) begin
         ms_r <= 1'b0;
      end else begin
         ms_r <= ms_r;
      end
   end

   assign ms_s = ms_r && ier_i[IER_MS];
`else
   logic unused_ms_s;

   assign unused_ms_s = ^{msr_delta_i, msr_rd_i, ier_i[IER_MS]};
   assign ms_s        = 1'b0;
`endif

   // Priority encode of enabled pending sources, highest first
   always_comb begin
      iir_s = IIR_NONE;
      if (rls_r && ier_i[IER_RLS]) begin
         iir_s = {IIR_RLS, 1'b0};
      end else if (rda_r && ier_i[IER_RDA]) begin
         iir_s = {IIR_RDA, 1'b0};
      end else if (cti_s && ier_i[IER_RDA]) begin
         iir_s = {IIR_CTI, 1'b0};
      end else if (thre_r && ier_i[IER_THRE]) begin
         iir_s = {IIR_THRE, 1'b0};
      end else if (ms_s) begin
         iir_s = {IIR_MS, 1'b0};
      end else begin
         iir_s = IIR_NONE;
      end
   end

   assign iir_o = iir_s;
   assign irq_o = ~iir_s[0];

endmodule : uart_irq_ctrl
